// File: rtl/hex_display_scheduler_pkg.sv
// Shared definitions for the HEX display scheduler: scan states, digit count,
// unlit pattern and the segment bit order used by the decoder and outputs.
package hex_display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int HDS_NUM_DIGITS = 4;

    // Segment vector bit order is {g,f,e,d,c,b,a}; bit 0 is segment a.
    // Segments are active-low, so a 1 turns the segment off.
    localparam int SEG_WIDTH = 7;
    typedef logic [SEG_WIDTH-1:0] seg_t;

    localparam seg_t HDS_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_scheduler_hex7seg.sv
// Shared nibble-to-segment decoder, active-low {g,f,e,d,c,b,a}.
module hex7seg
    import hex_display_scheduler_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup of the hex glyph for one nibble.
    always_comb begin
        seg = HDS_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = HDS_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one hex7seg decoder across four digits into a shadow
// buffer, then commits all digits to the outputs in a single edge.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | display stable, waiting for LOAD
//   ST_SCAN   | decoding digit idx into shadow, idx counts down 3..0
//   ST_COMMIT | copying shadow to HEX outputs, pulsing DONE, maybe restart
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int         NUM_DIGITS = HDS_NUM_DIGITS,
    parameter logic [6:0] BLANK      = HDS_BLANK
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [15:0] VALUE,
    input  logic        LOAD,
    input  logic        LZ_EN,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [1:0] IDX_TOP = 2'(NUM_DIGITS - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] work_val_q, work_val_d;
    logic        work_lz_q, work_lz_d;
    logic        zrun_q, zrun_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic        pend_lz_q, pend_lz_d;
    seg_t        shadow_q [NUM_DIGITS];
    seg_t        shadow_d [NUM_DIGITS];
    seg_t        hex_q [NUM_DIGITS];
    seg_t        hex_d [NUM_DIGITS];
    logic        done_q, done_d;

    logic [3:0]  nib;
    seg_t        seg_dec;

    assign nib = work_val_q[{idx_q, 2'b00} +: 4];

    hex7seg u_dec (
        .nibble (nib),
        .seg    (seg_dec)
    );

    // Next-state logic: scan sequencing, zero-run tracking and pending capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        work_val_d = work_val_q;
        work_lz_d  = work_lz_q;
        zrun_d     = zrun_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        pend_lz_d  = pend_lz_q;
        shadow_d   = shadow_q;
        hex_d      = hex_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    work_val_d = VALUE;
                    work_lz_d  = LZ_EN;
                    idx_d      = IDX_TOP;
                    zrun_d     = 1'b1;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // zrun_q means every more-significant nibble so far was zero.
                if (work_lz_q && zrun_q && (nib == 4'd0) && (idx_q != 2'd0)) begin
                    shadow_d[idx_q] = BLANK;
                end else begin
                    shadow_d[idx_q] = seg_dec;
                end
                if (nib != 4'd0) begin
                    zrun_d = 1'b0;
                end
                if (idx_q == 2'd0) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
                if (LOAD) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = VALUE;
                    pend_lz_d  = LZ_EN;
                end
            end

            ST_COMMIT: begin
                hex_d  = shadow_q;
                done_d = 1'b1;
                // A LOAD landing on the commit cycle is the newest request,
                // so it supersedes whatever is pending.
                if (LOAD) begin
                    work_val_d = VALUE;
                    work_lz_d  = LZ_EN;
                    pend_vld_d = 1'b0;
                    idx_d      = IDX_TOP;
                    zrun_d     = 1'b1;
                    state_d    = ST_SCAN;
                end else if (pend_vld_q) begin
                    work_val_d = pend_val_q;
                    work_lz_d  = pend_lz_q;
                    pend_vld_d = 1'b0;
                    idx_d      = IDX_TOP;
                    zrun_d     = 1'b1;
                    state_d    = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset to a blank display.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            work_val_q <= '0;
            work_lz_q  <= 1'b0;
            zrun_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            pend_lz_q  <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= BLANK;
                hex_q[i]    <= BLANK;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            work_val_q <= work_val_d;
            work_lz_q  <= work_lz_d;
            zrun_q     <= zrun_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            pend_lz_q  <= pend_lz_d;
            done_q     <= done_d;
            shadow_q   <= shadow_d;
            hex_q      <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// request/latency reference model of the display scheduler.
module tb_hex_display_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [15:0] VALUE;
    logic        LOAD;
    logic        LZ_EN;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        BUSY, DONE;

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_display_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .VALUE    (VALUE),
        .LOAD     (LOAD),
        .LZ_EN    (LZ_EN),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: a request is displayed 5 edges after it is accepted;
    // at most one newer request waits behind it (last wins).
    logic [6:0]  m_hex [4];
    int          m_rem;
    logic [15:0] m_cur_v;
    logic        m_cur_lz;
    logic        m_pend;
    logic [15:0] m_pv;
    logic        m_plz;
    logic        m_done;
    int          done_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_digit(input logic [15:0] v, input logic lz, input int i);
        logic [15:0] upper;
        logic [3:0]  n;
        upper = v >> (4 * i);
        n     = upper[3:0];
        if (lz && i != 0 && upper == 16'd0) return 7'h7F;
        return seg_tab[n];
    endfunction

    task automatic model_edge(input logic rst, input logic ld, input logic [15:0] v, input logic lz);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_hex[i] = 7'h7F;
            m_rem  = 0;
            m_pend = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    for (int i = 0; i < 4; i++) m_hex[i] = exp_digit(m_cur_v, m_cur_lz, i);
                    m_done = 1'b1;
                    if (ld) begin
                        m_cur_v = v; m_cur_lz = lz; m_rem = 5; m_pend = 1'b0;
                    end else if (m_pend) begin
                        m_cur_v = m_pv; m_cur_lz = m_plz; m_rem = 5; m_pend = 1'b0;
                    end
                end else if (ld) begin
                    m_pend = 1'b1; m_pv = v; m_plz = lz;
                end
            end else if (ld) begin
                m_cur_v = v; m_cur_lz = lz; m_rem = 5;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare on negedge.
    task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic lz);
        RESET = rst; LOAD = ld; VALUE = v; LZ_EN = lz;
        @(posedge CLOCK_50);
        model_edge(rst, ld, v, lz);
        @(negedge CLOCK_50);
        chk("hex0", {25'd0, HEX0}, {25'd0, m_hex[0]});
        chk("hex1", {25'd0, HEX1}, {25'd0, m_hex[1]});
        chk("hex2", {25'd0, HEX2}, {25'd0, m_hex[2]});
        chk("hex3", {25'd0, HEX3}, {25'd0, m_hex[3]});
        chk("busy", {31'd0, BUSY}, {31'd0, (m_rem > 0)});
        chk("done", {31'd0, DONE}, {31'd0, m_done});
        if (DONE) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic chk_disp(input string tag, input logic [27:0] exp);
        chk(tag, {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, exp});
    endtask

    initial begin
        int d0;
        logic [31:0] r;
        RESET = 1'b1; LOAD = 1'b0; VALUE = '0; LZ_EN = 1'b0;
        m_rem = 0; m_pend = 1'b0; m_done = 1'b0; m_cur_v = '0; m_cur_lz = 1'b0;
        m_pv = '0; m_plz = 1'b0; done_cnt = 0;
        for (int i = 0; i < 4; i++) m_hex[i] = 7'h7F;

        step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk_disp("reset_hex", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("reset_busy", {31'd0, BUSY}, 32'd0);

        // Basic load
        d0 = done_cnt;
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(4);
        chk_disp("basic_hold", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        idle(1);
        chk_disp("basic_hex", {7'h79, 7'h24, 7'h30, 7'h19});
        chk("basic_done", {31'd0, DONE}, 32'd1);
        idle(2);
        chk("basic_done_cnt", done_cnt - d0, 32'd1);

        // Suppression
        step(1'b0, 1'b1, 16'h0050, 1'b1);
        idle(5);
        chk_disp("lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40});
        idle(1);

        // Zero value, then no zeros
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(5);
        chk_disp("lz_0000", {7'h7F, 7'h7F, 7'h7F, 7'h40});
        step(1'b0, 1'b1, 16'hABCF, 1'b1);
        idle(5);
        chk_disp("lz_abcf", {7'h08, 7'h03, 7'h46, 7'h0E});
        idle(1);

        // Pending, last wins
        d0 = done_cnt;
        step(1'b0, 1'b1, 16'h1111, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 16'h2222, 1'b0);
        step(1'b0, 1'b1, 16'h3333, 1'b0);
        idle(2);
        chk_disp("pend_1111", {7'h79, 7'h79, 7'h79, 7'h79});
        idle(4);
        chk_disp("pend_still_1111", {7'h79, 7'h79, 7'h79, 7'h79});
        idle(1);
        chk_disp("pend_3333", {7'h30, 7'h30, 7'h30, 7'h30});
        idle(3);
        chk("pend_done_cnt", done_cnt - d0, 32'd2);

        // Reset mid-scan
        d0 = done_cnt;
        step(1'b0, 1'b1, 16'h9876, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk_disp("rst_mid_hex", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        idle(6);
        chk("rst_mid_no_done", done_cnt - d0, 32'd0);
        step(1'b0, 1'b1, 16'h4321, 1'b0);
        idle(5);
        chk_disp("after_rst", {7'h19, 7'h30, 7'h24, 7'h79});

        // Atomic update
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk_disp("atomic_hold", {7'h79, 7'h24, 7'h30, 7'h19});
        end
        idle(1);
        chk_disp("atomic_new", {7'h12, 7'h02, 7'h78, 7'h00});

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 16'(r >> (4 * $urandom_range(0, 4))), 1'($urandom));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_scheduler.md
HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of HEX digits sequenced; fixed at 4 in this revision.
REQ-002 Parameter BLANK, default 7'h7F, segment pattern for an unlit digit.
REQ-003 CLOCK_50  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 VALUE  input  16  four hex nibbles; VALUE[15:12] drives HEX3 and VALUE[3:0] drives HEX0.
REQ-006 LOAD  input  1  single-cycle request to display VALUE.
REQ-007 LZ_EN  input  1  leading-zero suppression enable, sampled together with VALUE.
REQ-008 HEX0, HEX1, HEX2, HEX3  output  7 each  registered segment patterns: {g,f,e,d,c,b,a}, active-low.
REQ-009 BUSY  output  1  high while a scan or commit is in progress.
REQ-010 DONE  output  1  one-cycle pulse after the HEX outputs update.

Function
REQ-011 A single shared nibble-to-segment decoder SHALL be time-multiplexed across all digits; the block SHALL NOT instantiate one decoder per digit.
REQ-012 States: IDLE, SCAN (digit index 3 down to 0), COMMIT.
REQ-013 IDLE transitions: LOAD=1 at edge k captures VALUE and LZ_EN into a working register, then enters SCAN with index 3.
REQ-014 SCAN behaviour: at each of edges k+1..k+4, decode the nibble at the current index into shadow[index], then decrement the index; after index 0, the next state SHALL be COMMIT.
REQ-015 COMMIT behaviour: at edge k+5, HEX0..HEX3 SHALL load all four shadow values atomically; a mixed old/new display SHALL never be visible.
REQ-016 DONE timing: DONE SHALL be 1 for exactly the cycle after edge k+5; the fixed latency from LOAD to display SHALL be 5 cycles.
REQ-017 BUSY SHALL equal (state != IDLE).
REQ-018 Leading-zero suppression with LZ_EN=1: a digit SHALL be written as BLANK when its nibble and all more-significant nibbles are 0.
REQ-019 HEX0 SHALL never be blanked by suppression, so a value of 0 shows a single "0".
REQ-020 With LZ_EN=0, all four digits SHALL be decoded.
REQ-021 Loads while busy: a LOAD while BUSY=1 (including the COMMIT cycle) SHALL be stored in a one-deep pending register (VALUE, LZ_EN); a later LOAD before restart overwrites it, so the last request wins.
REQ-022 Pending restart: if pending is valid at COMMIT, the next state SHALL be SCAN (index 3) on the pending data, pending SHALL clear, and BUSY SHALL stay 1.
REQ-023 Decoder encoding: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
REQ-024 LOAD in IDLE with no pending SHALL take effect immediately; no request SHALL be dropped except those overwritten under REQ-021.

Reset
REQ-025 On RESET=1 at an edge, the following SHALL hold: state=IDLE, pending cleared, HEX0..HEX3=BLANK, shadow=BLANK, BUSY=0, DONE=0.
REQ-026 RESET SHALL take priority over LOAD and over any in-flight scan; an interrupted scan SHALL NOT commit and SHALL NOT pulse DONE.

Structure
REQ-027 A shared package SHALL hold the state enumeration, NUM_DIGITS, BLANK and the segment bit-order definition.
REQ-028 The decoder SHALL be one combinational sub-module, hex7seg, that is 4-bit in and 7-bit out and matches REQ-023; it is the only sub-module.

Verification
REQ-029 Basic load: reset, then LOAD VALUE=16'h1234, LZ_EN=0 -> after 5 cycles HEX3..0 = 79,24,30,19, DONE pulses once, and BUSY is high for 5 cycles.
REQ-030 Suppression: LOAD 16'h0050, LZ_EN=1 -> HEX3=7F, HEX2=7F, HEX1=12, HEX0=40.
REQ-031 Zero value: LOAD 16'h0000, LZ_EN=1 -> HEX3..1=7F, HEX0=40; then LOAD 16'hABCF, LZ_EN=1 -> 08,03,46,0E.
REQ-032 Pending: LOAD 16'h1111 at cycle 0, 16'h2222 at cycle 2, 16'h3333 at cycle 3 -> display shows 1111 after cycle 5 and 3333 after cycle 10; 2222 is never shown; DONE pulses twice.
REQ-033 Reset mid-scan: RESET at cycle 2 after a LOAD -> all HEX=7F, no DONE, BUSY=0 the next cycle; a subsequent LOAD completes normally.
REQ-034 Atomic update: HEX holds 16'h1234, then LOAD 16'h5678 -> HEX outputs stay 1234 for 4 cycles and switch together to 12,02,78,00.
